alu_issue: RTL

Issue and writeback stage wrapped around the 8-bit `alu`. Accepts 16-bit ALU instructions over a valid/ready handshake, reads two operands from an 8×8 register file, and drives `a`/`b`/`op`/`shamt` of the registered-output ALU. One cycle later it writes the ALU result back to the register file and latches the flags into a status register. Sits between instruction fetch/decode and the `alu`.

---
 rtl/alu_issue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// alu_issue: issue and writeback stage around the registered-output 8-bit alu.
// Two occupancy bits (ex_valid, wb_valid) form the whole pipeline; an 8x8
// register file supplies operands and takes the ALU result one cycle later.
// Optional build macro ALU_ISSUE_FWD_EN: WB->EX forwarding, one instruction
// per cycle. Without it, issue is throttled to one instruction per 2 cycles.
module alu_issue #(
    parameter logic [7:0] RF_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [15:0] ins,
    input  logic       ins_valid,
    output logic       ins_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic [2:0] alu_shamt,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flags,
    output logic [3:0] status,
    output logic       retire,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned NREG = 8;

    logic [DW-1:0] rf [NREG];

    logic          ex_valid;
    logic [2:0]    ex_op;
    logic [AW-1:0] ex_rd;
    logic [AW-1:0] ex_rs1;
    logic [AW-1:0] ex_rs2;
    logic          ex_fe;
    logic [2:0]    ex_shamt;

    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          wb_fe;

    logic          accept;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;

    // N and C from the alu are not architected
    logic unused_flags;
    assign unused_flags = ^alu_flags[2:1];

`ifdef ALU_ISSUE_FWD_EN
    assign ins_ready = 1'b1;
`else
    assign ins_ready = !ex_valid;
`endif

    assign accept = ins_valid && ins_ready;
    assign retire = wb_valid;

    // Occupancy bits, register file and status; synchronous reset drops in-flight work
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            wb_valid <= 1'b0;
            status   <= 4'h0;
            rf[0]    <= '0;
            for (int i = 1; i < int'(NREG); i++) begin
                rf[i] <= RF_RESET;
            end
        end else begin
            ex_valid <= accept;
            wb_valid <= ex_valid;
            if (wb_valid) begin
                if (wb_rd != '0) begin
                    rf[wb_rd] <= alu_out;
                end
                if (wb_fe) begin
                    status <= {alu_flags[3], 2'b00, alu_flags[0]};
                end
            end
        end
    end

    // EX and WB slot payloads; qualified by the occupancy bits, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            ex_op    <= ins[15:13];
            ex_rd    <= ins[12:10];
            ex_rs1   <= ins[9:7];
            ex_rs2   <= ins[6:4];
            ex_fe    <= ins[3];
            ex_shamt <= ins[2:0];
        end
        if (ex_valid) begin
            wb_rd <= ex_rd;
            wb_fe <= ex_fe;
        end
    end

    // Operand read, optional forwarding from the instruction in WB
    always_comb begin
        src_a = (ex_rs1 == '0) ? '0 : rf[ex_rs1];
        src_b = (ex_rs2 == '0) ? '0 : rf[ex_rs2];
`ifdef ALU_ISSUE_FWD_EN
        if (wb_valid && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
            src_a = alu_out;
        end
        if (wb_valid && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
            src_b = alu_out;
        end
`endif
    end

    // ALU drive is quiet when the EX slot is empty
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        alu_shamt = '0;
        if (ex_valid) begin
            alu_a     = src_a;
            alu_b     = src_b;
            alu_op    = ex_op;
            alu_shamt = ex_shamt;
        end
    end

    // Debug port shows committed state only
    always_comb begin
        dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];
    end

endmodule
